// File: rtl/placement_registry_if.sv
// rtl/placement_registry_if.sv - candidate probe and nest/patch commit ports of the placement registry
interface placement_registry_if #(
    parameter int NEST_num_bits       = 2,
    parameter int SUGARPATCH_num_bits = 3,
    parameter int X_bits              = 8,
    parameter int Y_bits              = 7
);
    logic [X_bits-1:0]              collide_x;
    logic [Y_bits-1:0]              collide_y;
    logic                           collision;
    logic                           nest_wr;
    logic [NEST_num_bits-1:0]       nest_id;
    logic [X_bits-1:0]              nest_x;
    logic [Y_bits-1:0]              nest_y;
    logic                           patch_wr;
    logic [SUGARPATCH_num_bits-1:0] patch_id;
    logic [X_bits-1:0]              patch_x;
    logic [Y_bits-1:0]              patch_y;

    modport master (
        output collide_x, collide_y, nest_wr, nest_id, nest_x, nest_y,
               patch_wr, patch_id, patch_x, patch_y,
        input  collision
    );

    modport slave (
        input  collide_x, collide_y, nest_wr, nest_id, nest_x, nest_y,
               patch_wr, patch_id, patch_x, patch_y,
        output collision
    );
endinterface

// File: rtl/placement_registry.sv
// rtl/placement_registry.sv - setup-phase nest/patch coordinate store with Chebyshev proximity check
module placement_registry #(
    parameter int NEST_num            = 4,
    parameter int NEST_num_bits       = 2,
    parameter int SUGARPATCH_num      = 8,
    parameter int SUGARPATCH_num_bits = 3,
    parameter int X_bits              = 8,
    parameter int Y_bits              = 7,
    parameter int MIN_SEP             = 4
) (
    input  logic                           setup_clk,
    input  logic                           RESET_SIM,
    input  logic                           SETUP_MODE,
    placement_registry_if.slave            bus,
    output logic [X_bits-1:0]              nests_X   [NEST_num],
    output logic [Y_bits-1:0]              nests_Y   [NEST_num],
    output logic [X_bits-1:0]              patches_X [SUGARPATCH_num],
    output logic [Y_bits-1:0]              patches_Y [SUGARPATCH_num],
    output logic [NEST_num_bits:0]         nest_count,
    output logic [SUGARPATCH_num_bits:0]   patch_count,
    output logic                           reg_full,
    output logic                           locked,
    output logic                           wr_err
);
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [NEST_num_bits:0]       NEST_MAX  = (NEST_num_bits+1)'(NEST_num);
    localparam logic [SUGARPATCH_num_bits:0] PATCH_MAX = (SUGARPATCH_num_bits+1)'(SUGARPATCH_num);

    state_t                         state_q, state_d;
    logic [X_bits-1:0]              nest_x_q  [NEST_num];
    logic [X_bits-1:0]              nest_x_d  [NEST_num];
    logic [Y_bits-1:0]              nest_y_q  [NEST_num];
    logic [Y_bits-1:0]              nest_y_d  [NEST_num];
    logic [NEST_num-1:0]            nest_vld_q, nest_vld_d;
    logic [X_bits-1:0]              patch_x_q [SUGARPATCH_num];
    logic [X_bits-1:0]              patch_x_d [SUGARPATCH_num];
    logic [Y_bits-1:0]              patch_y_q [SUGARPATCH_num];
    logic [Y_bits-1:0]              patch_y_d [SUGARPATCH_num];
    logic [SUGARPATCH_num-1:0]      patch_vld_q, patch_vld_d;
    logic [NEST_num_bits:0]         nest_count_q, nest_count_d;
    logic [SUGARPATCH_num_bits:0]   patch_count_q, patch_count_d;
    logic                           wr_err_q, wr_err_d;
    logic                           setup_q, setup_d;

    logic nest_acc, patch_acc, setup_fall, full_d, collision_c;

    // Differences carry one extra sign bit so coordinates near 0 never alias with far edges.
    function automatic logic near_x(input logic [X_bits-1:0] a, input logic [X_bits-1:0] b);
        logic signed [X_bits:0] d;
        logic [X_bits:0]        m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[X_bits] ? $unsigned(-d) : $unsigned(d);
        return m < (X_bits+1)'(MIN_SEP);
    endfunction

    function automatic logic near_y(input logic [Y_bits-1:0] a, input logic [Y_bits-1:0] b);
        logic signed [Y_bits:0] d;
        logic [Y_bits:0]        m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[Y_bits] ? $unsigned(-d) : $unsigned(d);
        return m < (Y_bits+1)'(MIN_SEP);
    endfunction

    always_comb begin
        collision_c = 1'b0;
        for (int i = 0; i < NEST_num; i++) begin
            if (nest_vld_q[i] && near_x(bus.collide_x, nest_x_q[i]) && near_y(bus.collide_y, nest_y_q[i]))
                collision_c = 1'b1;
        end
        for (int i = 0; i < SUGARPATCH_num; i++) begin
            if (patch_vld_q[i] && near_x(bus.collide_x, patch_x_q[i]) && near_y(bus.collide_y, patch_y_q[i]))
                collision_c = 1'b1;
        end
    end

    always_comb begin
        nest_x_d      = nest_x_q;
        nest_y_d      = nest_y_q;
        nest_vld_d    = nest_vld_q;
        patch_x_d     = patch_x_q;
        patch_y_d     = patch_y_q;
        patch_vld_d   = patch_vld_q;
        nest_count_d  = nest_count_q;
        patch_count_d = patch_count_q;
        wr_err_d      = wr_err_q;
        setup_d       = SETUP_MODE;
        state_d       = state_q;

        nest_acc   = bus.nest_wr && (state_q != ST_LOCKED) && (int'(bus.nest_id) < NEST_num);
        patch_acc  = bus.patch_wr && (state_q != ST_LOCKED) && (int'(bus.patch_id) < SUGARPATCH_num);
        setup_fall = setup_q && !SETUP_MODE;

        if (bus.nest_wr && !nest_acc)
            wr_err_d = 1'b1;
        if (bus.patch_wr && !patch_acc)
            wr_err_d = 1'b1;

        if (nest_acc) begin
            nest_x_d[bus.nest_id]   = bus.nest_x;
            nest_y_d[bus.nest_id]   = bus.nest_y;
            nest_vld_d[bus.nest_id] = 1'b1;
            if (!nest_vld_q[bus.nest_id])
                nest_count_d = nest_count_q + (NEST_num_bits+1)'(1);
        end
        if (patch_acc) begin
            patch_x_d[bus.patch_id]   = bus.patch_x;
            patch_y_d[bus.patch_id]   = bus.patch_y;
            patch_vld_d[bus.patch_id] = 1'b1;
            if (!patch_vld_q[bus.patch_id])
                patch_count_d = patch_count_q + (SUGARPATCH_num_bits+1)'(1);
        end

        full_d = (nest_count_d == NEST_MAX) && (patch_count_d == PATCH_MAX);

        case (state_q)
            ST_EMPTY:   if (nest_acc || patch_acc) state_d = full_d ? ST_FULL : ST_FILLING;
            ST_FILLING: if (full_d) state_d = ST_FULL;
            ST_FULL:    state_d = ST_FULL;
            ST_LOCKED:  state_d = ST_LOCKED;
            default:    state_d = ST_EMPTY;
        endcase
        // A same-cycle write is still accepted above; the lock only binds later cycles.
        if (setup_fall)
            state_d = ST_LOCKED;
    end

    always_ff @(posedge setup_clk or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state_q       <= ST_EMPTY;
            nest_x_q      <= '{default: '0};
            nest_y_q      <= '{default: '0};
            nest_vld_q    <= '0;
            patch_x_q     <= '{default: '0};
            patch_y_q     <= '{default: '0};
            patch_vld_q   <= '0;
            nest_count_q  <= '0;
            patch_count_q <= '0;
            wr_err_q      <= 1'b0;
            setup_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            nest_x_q      <= nest_x_d;
            nest_y_q      <= nest_y_d;
            nest_vld_q    <= nest_vld_d;
            patch_x_q     <= patch_x_d;
            patch_y_q     <= patch_y_d;
            patch_vld_q   <= patch_vld_d;
            nest_count_q  <= nest_count_d;
            patch_count_q <= patch_count_d;
            wr_err_q      <= wr_err_d;
            setup_q       <= setup_d;
        end
    end

    assign bus.collision = collision_c;
    assign nests_X       = nest_x_q;
    assign nests_Y       = nest_y_q;
    assign patches_X     = patch_x_q;
    assign patches_Y     = patch_y_q;
    assign nest_count    = nest_count_q;
    assign patch_count   = patch_count_q;
    assign reg_full      = (nest_count_q == NEST_MAX) && (patch_count_q == PATCH_MAX);
    assign locked        = (state_q == ST_LOCKED);
    assign wr_err        = wr_err_q;
endmodule

// File: tb/tb_placement_registry.sv
// tb/tb_placement_registry.sv - randomized bench for placement_registry against a slot-list reference model
module tb_placement_registry;
    localparam int NN = 4;
    localparam int NP = 8;
    localparam int SEP = 4;

    logic setup_clk = 1'b0;
    logic RESET_SIM = 1'b1;
    logic SETUP_MODE = 1'b1;

    logic [7:0] nests_X   [NN];
    logic [6:0] nests_Y   [NN];
    logic [7:0] patches_X [NP];
    logic [6:0] patches_Y [NP];
    logic [2:0] nest_count;
    logic [3:0] patch_count;
    logic       reg_full, locked, wr_err;

    placement_registry_if #(.NEST_num_bits(2), .SUGARPATCH_num_bits(3), .X_bits(8), .Y_bits(7)) bus ();

    placement_registry #(
        .NEST_num(NN), .NEST_num_bits(2), .SUGARPATCH_num(NP), .SUGARPATCH_num_bits(3),
        .X_bits(8), .Y_bits(7), .MIN_SEP(SEP)
    ) dut (
        .setup_clk(setup_clk), .RESET_SIM(RESET_SIM), .SETUP_MODE(SETUP_MODE), .bus(bus),
        .nests_X(nests_X), .nests_Y(nests_Y), .patches_X(patches_X), .patches_Y(patches_Y),
        .nest_count(nest_count), .patch_count(patch_count),
        .reg_full(reg_full), .locked(locked), .wr_err(wr_err)
    );

    always #5 setup_clk = ~setup_clk;

    int n_checks = 0;
    int n_errs = 0;

    // reference model: plain slot lists; state 0 empty, 1 filling, 2 full, 3 locked
    int m_nx[NN], m_ny[NN], m_px[NP], m_py[NP];
    bit m_nv[NN], m_pv[NP];
    bit m_err, m_setup_prev;
    int m_state;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cnt_n();
        int c = 0;
        for (int i = 0; i < NN; i++) c += int'(m_nv[i]);
        return c;
    endfunction

    function automatic int cnt_p();
        int c = 0;
        for (int i = 0; i < NP; i++) c += int'(m_pv[i]);
        return c;
    endfunction

    function automatic bit model_collide(input int x, input int y);
        bit hit = 0;
        for (int i = 0; i < NN; i++)
            if (m_nv[i] && iabs(x - m_nx[i]) < SEP && iabs(y - m_ny[i]) < SEP) hit = 1;
        for (int i = 0; i < NP; i++)
            if (m_pv[i] && iabs(x - m_px[i]) < SEP && iabs(y - m_py[i]) < SEP) hit = 1;
        return hit;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin m_nx[i] = 0; m_ny[i] = 0; m_nv[i] = 0; end
        for (int i = 0; i < NP; i++) begin m_px[i] = 0; m_py[i] = 0; m_pv[i] = 0; end
        m_err = 0;
        m_setup_prev = 0;
        m_state = 0;
    endtask

    task automatic do_cycle(input bit nwr, input int nid, input int nx, input int ny,
                            input bit pwr, input int pid, input int px, input int py, input bit setup);
        bit na, pa, fall, full;
        bus.nest_wr  = nwr;
        bus.nest_id  = 2'(nid);
        bus.nest_x   = 8'(nx);
        bus.nest_y   = 7'(ny);
        bus.patch_wr = pwr;
        bus.patch_id = 3'(pid);
        bus.patch_x  = 8'(px);
        bus.patch_y  = 7'(py);
        SETUP_MODE   = setup;
        na   = nwr && (m_state != 3);
        pa   = pwr && (m_state != 3);
        fall = m_setup_prev && !setup;
        @(posedge setup_clk);
        if ((nwr && !na) || (pwr && !pa)) m_err = 1;
        if (na) begin m_nx[nid] = nx & 255; m_ny[nid] = ny & 127; m_nv[nid] = 1; end
        if (pa) begin m_px[pid] = px & 255; m_py[pid] = py & 127; m_pv[pid] = 1; end
        full = (cnt_n() == NN) && (cnt_p() == NP);
        m_setup_prev = setup;
        if (m_state != 3) begin
            if (fall) m_state = 3;
            else if (m_state == 0 && (na || pa)) m_state = full ? 2 : 1;
            else if (m_state == 1 && full) m_state = 2;
        end
        #1;
        bus.nest_wr  = 0;
        bus.patch_wr = 0;
    endtask

    task automatic probe(input string tag, input int x, input int y);
        bus.collide_x = 8'(x);
        bus.collide_y = 7'(y);
        #1;
        chk(tag, 32'(bus.collision), 32'(model_collide(x & 255, y & 127)));
    endtask

    task automatic probe_rand(input string tag);
        int x, y, k;
        if ($urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, NN + NP - 1);
            x = (k < NN) ? m_nx[k] : m_px[k - NN];
            y = (k < NN) ? m_ny[k] : m_py[k - NN];
            x = (x + $urandom_range(0, 10) - 5) & 255;
            y = (y + $urandom_range(0, 10) - 5) & 127;
        end else begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 127);
        end
        probe(tag, x, y);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nest_count"}, 32'(nest_count), 32'(cnt_n()));
        chk({tag, ".patch_count"}, 32'(patch_count), 32'(cnt_p()));
        chk({tag, ".reg_full"}, 32'(reg_full), 32'((cnt_n() == NN) && (cnt_p() == NP)));
        chk({tag, ".locked"}, 32'(locked), 32'(m_state == 3));
        chk({tag, ".wr_err"}, 32'(wr_err), 32'(m_err));
        chk({tag, ".state"}, 32'(dut.state_q), 32'(m_state));
        for (int i = 0; i < NN; i++) begin
            chk($sformatf("%s.nx%0d", tag, i), 32'(nests_X[i]), 32'(m_nx[i]));
            chk($sformatf("%s.ny%0d", tag, i), 32'(nests_Y[i]), 32'(m_ny[i]));
        end
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s.px%0d", tag, i), 32'(patches_X[i]), 32'(m_px[i]));
            chk($sformatf("%s.py%0d", tag, i), 32'(patches_Y[i]), 32'(m_py[i]));
        end
    endtask

    initial begin
        bus.collide_x = 0; bus.collide_y = 0;
        bus.nest_wr = 0; bus.nest_id = 0; bus.nest_x = 0; bus.nest_y = 0;
        bus.patch_wr = 0; bus.patch_id = 0; bus.patch_x = 0; bus.patch_y = 0;
        model_reset();
        #22;
        @(negedge setup_clk);
        RESET_SIM = 0;

        probe("empty_probe", 10, 10);
        check_all("reset");

        do_cycle(1, 0, 50, 20, 0, 0, 0, 0, 1);
        probe("near_53_23", 53, 23);
        probe("far_54_20", 54, 20);
        probe("near_47_17", 47, 17);
        check_all("nest0");

        do_cycle(1, 0, 0, 0, 1, 3, 255, 127, 1);
        probe("low_3_3", 3, 3);
        probe("low_edge_0_0", 0, 0);
        probe("high_252_124", 252, 124);
        probe("mid_128_64", 128, 64);
        do_cycle(1, 0, 100, 60, 0, 0, 0, 0, 1);
        chk("overwrite_nx0", 32'(nests_X[0]), 32'd100);
        check_all("overwrite");

        for (int c = 0; c < 40; c++) begin
            do_cycle($urandom_range(0, 1), $urandom_range(0, NN - 1), $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 1), $urandom_range(0, NP - 1), $urandom_range(0, 255), $urandom_range(0, 127), 1);
            probe_rand($sformatf("rnd_probe%0d", c));
            if (c % 8 == 7) check_all($sformatf("rnd%0d", c));
        end

        for (int i = 0; i < NP; i++)
            do_cycle(i < NN, i, $urandom_range(0, 255), $urandom_range(0, 127),
                     1, i, $urandom_range(0, 255), $urandom_range(0, 127), 1);
        chk("full_reg_full", 32'(reg_full), 32'd1);
        chk("full_state", 32'(dut.state_q), 32'd2);
        do_cycle(0, 0, 0, 0, 1, 7, 200, 100, 1);
        chk("full_overwrite_px7", 32'(patches_X[7]), 32'd200);
        check_all("full_ovw");
        for (int c = 0; c < 8; c++) probe_rand($sformatf("full_probe%0d", c));

        do_cycle(1, 1, 77, 33, 0, 0, 0, 0, 0);
        chk("lock_nx1", 32'(nests_X[1]), 32'd77);
        chk("lock_locked", 32'(locked), 32'd1);
        check_all("lock");
        do_cycle(0, 0, 0, 0, 1, 2, 9, 9, 0);
        chk("locked_wr_err", 32'(wr_err), 32'd1);
        check_all("locked_wr");
        for (int c = 0; c < 6; c++)
            do_cycle($urandom_range(0, 1), $urandom_range(0, NN - 1), $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 1), $urandom_range(0, NP - 1), $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 1));
        check_all("locked_rnd");

        RESET_SIM = 1;
        @(negedge setup_clk);
        RESET_SIM = 0;
        model_reset();
        for (int c = 0; c < 3; c++)
            do_cycle(1, c, $urandom_range(0, 255), $urandom_range(0, 127),
                     1, c, $urandom_range(0, 255), $urandom_range(0, 127), 1);
        check_all("refill");
        #2;
        RESET_SIM = 1;
        model_reset();
        #1;
        check_all("async_rst");
        probe("async_rst_probe", m_nx[0], m_ny[0]);
        @(negedge setup_clk);
        RESET_SIM = 0;
        chk("post_rst_state", 32'(dut.state_q), 32'd0);
        do_cycle(0, 0, 0, 0, 1, 5, 40, 40, 1);
        chk("post_rst_filling", 32'(dut.state_q), 32'd1);
        probe("post_rst_near", 42, 38);
        check_all("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/placement_registry.md
# placement_registry

Setup-phase store of every nest and sugar-patch coordinate, with a proximity check against all stored objects. It sits beside the simulation initializer: the initializer proposes random coordinates on `collide_x/collide_y`, reads `collision` in the same cycle, and commits accepted positions here through the nest or patch write ports. The registry drives the nest coordinate arrays used to spawn ants, and the patch arrays consumed by the location-map stage. It locks once setup ends.

## Interface
Parameters:
- `NEST_num`, 4: number of nest slots.
- `NEST_num_bits`, 2: index width, equal to clog2(NEST_num).
- `SUGARPATCH_num`, 8: number of patch slots.
- `SUGARPATCH_num_bits`, 3: patch index width.
- `X_bits`, 8: x coordinate width.
- `Y_bits`, 7: y coordinate width.
- `MIN_SEP`, 4: minimum Chebyshev separation between objects, in cells; range 1..127.

Ports:
- `setup_clk`, in, 1: clock.
- `RESET_SIM`, in, 1: asynchronous, active-high reset.
- `SETUP_MODE`, in, 1: high while the initializer owns the simulation.
- `collide_x`, in, X_bits: candidate x.
- `collide_y`, in, Y_bits: candidate y.
- `collision`, out, 1: the candidate is too close to a stored object; combinational.
- `nest_wr`, in, 1: commit a nest.
- `nest_id`, in, NEST_num_bits: nest slot.
- `nest_x`, in, X_bits: nest x.
- `nest_y`, in, Y_bits: nest y.
- `patch_wr`, in, 1: commit a patch.
- `patch_id`, in, SUGARPATCH_num_bits: patch slot.
- `patch_x`, in, X_bits: patch x.
- `patch_y`, in, Y_bits: patch y.
- `nests_X`, out, [NEST_num][X_bits]: nest x array.
- `nests_Y`, out, [NEST_num][Y_bits]: nest y array.
- `patches_X`, out, [SUGARPATCH_num][X_bits]: patch x array.
- `patches_Y`, out, [SUGARPATCH_num][Y_bits]: patch y array.
- `nest_count`, out, NEST_num_bits+1: number of valid nest slots.
- `patch_count`, out, SUGARPATCH_num_bits+1: number of valid patch slots.
- `reg_full`, out, 1: all nest and patch slots are valid.
- `locked`, out, 1: registry is frozen.
- `wr_err`, out, 1: sticky error flag; cleared only by reset.

## Operation
- Each slot holds x, y and a valid bit. Reset clears all coordinates, valid bits, counts, `wr_err` and `locked` to 0.
- `collision` is asserted when any valid slot, nest or patch, satisfies |collide_x − sx| < MIN_SEP and |collide_y − sy| < MIN_SEP.
  - Differences are computed with 1 extra sign bit, so no wrap-around occurs.
  - Invalid slots never collide. An empty registry gives `collision`=0.
- A nest write is accepted when `nest_wr`=1, `locked`=0 and `nest_id` < NEST_num.
  - An accepted write stores x and y and sets the slot's valid bit.
  - `nest_count` increments only if the slot was previously invalid. Overwriting a valid slot replaces the coordinates and leaves the count unchanged.
- Patch writes follow the same rules using the patch ports. Nest and patch writes in the same cycle are both accepted.
- A write that is not accepted because of lock or an out-of-range id sets `wr_err`. The rejected write leaves slot contents and counts unchanged.
- The registry does not enforce separation on writes. The writer must check `collision` first.
- State machine (`state`, 2 bits):
  - EMPTY → FILLING on the first accepted write.
  - FILLING → FULL when both counts reach their maximum.
  - EMPTY, FILLING or FULL → LOCKED on a falling edge of SETUP_MODE, detected with a registered copy of SETUP_MODE.
  - LOCKED persists until RESET_SIM.
  - `locked` = (state==LOCKED). `reg_full` = (both counts at maximum).
- Outputs are sized exactly. Unused array entries read 0.

## Timing
- `collision` has zero latency from `collide_x/y` and reflects slot contents as of the last clock edge.
- A write committed at edge N is visible on the arrays, counts and `collision` after edge N. A candidate proposed in the following cycle therefore sees the new object.
- A write and a SETUP_MODE fall in the same cycle: the write is accepted, and lock takes effect at that edge for all later cycles.
- Asserting RESET_SIM mid-fill immediately clears all outputs asynchronously. After release, the state is EMPTY.
- A write on the first edge after reset release is accepted.

## Test plan
- Reset, then probe `collide`=(10,10) → `collision`=0, counts=0, state EMPTY.
- Write nest 0 at (50,20); probe (53,23) → 1; probe (54,20) → 0; probe (47,17) → 1; `nest_count`=1.
- Write nest 0 at (0,0), then probe (3,3) → 1. This covers the low edge with no wrap: `collision` must not match a far slot at (255,127). Also write nest 0 again at (100,60) → `nest_count` remains 1 and `nests_X[0]`=100.
- Fill 4 nests and 8 patches → `reg_full`=1 and state FULL. Then write `patch_id`=7 → overwrite accepted, `wr_err`=0.
- Drive SETUP_MODE 1→0 with a same-cycle nest write to slot 1 → the write is stored and `locked`=1. A later `patch_wr` → contents unchanged and `wr_err`=1.
- Assert RESET_SIM asynchronously mid-fill → counts, arrays and `wr_err` are 0 immediately, and the next accepted write moves the state EMPTY→FILLING.
